shifter_arbiter: RTL and testbench

Shares the single-cycle `shifter` datapath of the or1420 core between two requesters: port 0 is the execute stage, port 1 is the custom-instruction/co-processor path. The block arbitrates every cycle, registers the winning operands, evaluates them through one `shifter` instance, and returns a registered result tagged to the winning port. It is fully pipelined: latency 2 cycles, throughput one operation per cycle, with an optional lock that lets a requester keep the datapath for back-to-back operations.

---
 rtl/shifter_arbiter_pkg.sv | 31 +++
 rtl/shifter_arbiter_shifter.sv | 31 +++
 rtl/shifter_arbiter.sv | 123 ++++++++++++
 tb/tb_shifter_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the shifter arbiter: shifter control codes, port-id width,
// lock-owner encoding and the stage-E operand record.
package shifter_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int CTRL_W    = 3;
    localparam int PORT_ID_W = 1;

    localparam logic [CTRL_W-1:0] SHIFT_MOVHI = 3'b010;
    localparam logic [CTRL_W-1:0] SHIFT_CMOV  = 3'b011;
    localparam logic [CTRL_W-1:0] SHIFT_SLL   = 3'b100;
    localparam logic [CTRL_W-1:0] SHIFT_SRL   = 3'b101;
    localparam logic [CTRL_W-1:0] SHIFT_SRA   = 3'b110;
    localparam logic [CTRL_W-1:0] SHIFT_ROR   = 3'b111;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic                 valid;
        logic [PORT_ID_W-1:0] id;
        logic [CTRL_W-1:0]    ctrl;
        logic                 flag;
        logic [DATA_W-1:0]    opA;
        logic [DATA_W-1:0]    opB;
    } stage_e_t;

endpackage

// File: rtl/shifter_arbiter_shifter.sv
// Single-cycle or1420 shifter datapath: movhi, cmov and the four shift/rotate ops.
// Codes outside that set produce zero.
module shifter_arbiter_shifter
    import shifter_arbiter_pkg::*;
(
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_flag,
    input  logic [DATA_W-1:0] i_opA,
    input  logic [DATA_W-1:0] i_opB,
    output logic [DATA_W-1:0] o_result
);

    logic [4:0] w_amt;

    assign w_amt = i_opB[4:0];

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            SHIFT_MOVHI: o_result = {i_opB[15:0], 16'h0000};
            SHIFT_CMOV:  o_result = i_flag ? i_opA : i_opB;
            SHIFT_SLL:   o_result = i_opA << w_amt;
            SHIFT_SRL:   o_result = i_opA >> w_amt;
            SHIFT_SRA:   o_result = $signed(i_opA) >>> w_amt;
            // A zero rotate shifts the left term out completely, leaving opA intact.
            SHIFT_ROR:   o_result = (i_opA >> w_amt) | (i_opA << (6'd32 - {1'b0, w_amt}));
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Two-port arbiter in front of one shared shifter; 2-cycle latency, one op per cycle.
// Define SHIFTER_ARBITER_RR_EN for round-robin priority, otherwise port 0 has fixed priority.
module shifter_arbiter
    import shifter_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [CTRL_W-1:0] ctrl0,
    input  logic [CTRL_W-1:0] ctrl1,
    input  logic              flag0,
    input  logic              flag1,
    input  logic [DATA_W-1:0] opA0,
    input  logic [DATA_W-1:0] opA1,
    input  logic [DATA_W-1:0] opB0,
    input  logic [DATA_W-1:0] opB1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] resultData
);

    owner_t               r_owner;
    stage_e_t             r_stageE;
    logic                 r_wValid;
    logic [PORT_ID_W-1:0] r_wId;
    logic [DATA_W-1:0]    r_result;
`ifdef SHIFTER_ARBITER_RR_EN
    logic                 r_ptr;
`endif

    logic                 w_grant0;
    logic                 w_grant1;
    stage_e_t             w_nextE;
    logic [DATA_W-1:0]    w_shiftOut;

    // A requesting lock owner always wins; otherwise fall back to the priority scheme.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_owner == OWN_P0 && req0) begin
            w_grant0 = 1'b1;
        end else if (r_owner == OWN_P1 && req1) begin
            w_grant1 = 1'b1;
        end else begin
`ifdef SHIFTER_ARBITER_RR_EN
            if (r_ptr == 1'b0) begin
                w_grant0 = req0;
                w_grant1 = req1 & ~req0;
            end else begin
                w_grant1 = req1;
                w_grant0 = req0 & ~req1;
            end
`else
            w_grant0 = req0;
            w_grant1 = req1 & ~req0;
`endif
        end
    end

    assign ack0 = w_grant0 & ~reset;
    assign ack1 = w_grant1 & ~reset;

    always_comb begin
        w_nextE       = '0;
        w_nextE.valid = ack0 | ack1;
        w_nextE.id    = ack1;
        w_nextE.ctrl  = ack1 ? ctrl1 : ctrl0;
        w_nextE.flag  = ack1 ? flag1 : flag0;
        w_nextE.opA   = ack1 ? opA1  : opA0;
        w_nextE.opB   = ack1 ? opB1  : opB0;
    end

    shifter_arbiter_shifter u_shifter (
        .i_ctrl   (r_stageE.ctrl),
        .i_flag   (r_stageE.flag),
        .i_opA    (r_stageE.opA),
        .i_opB    (r_stageE.opB),
        .o_result (w_shiftOut)
    );

    // Ownership lasts only while the owner keeps being accepted with its lock set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner  <= OWN_NONE;
            r_stageE <= '0;
            r_wValid <= 1'b0;
            r_wId    <= '0;
            r_result <= '0;
`ifdef SHIFTER_ARBITER_RR_EN
            r_ptr    <= 1'b0;
`endif
        end else begin
            r_stageE <= w_nextE;
            r_wValid <= r_stageE.valid;
            r_wId    <= r_stageE.id;
            if (r_stageE.valid) begin
                r_result <= w_shiftOut;
            end
            if (ack0) begin
                r_owner <= lock0 ? OWN_P0 : OWN_NONE;
            end else if (ack1) begin
                r_owner <= lock1 ? OWN_P1 : OWN_NONE;
            end else begin
                r_owner <= OWN_NONE;
            end
`ifdef SHIFTER_ARBITER_RR_EN
            if (ack0 | ack1) begin
                r_ptr <= ack0;
            end
`endif
        end
    end

    assign done0      = r_wValid & (r_wId == 1'b0);
    assign done1      = r_wValid & (r_wId == 1'b1);
    assign resultData = r_result;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter; expectations follow SHIFTER_ARBITER_RR_EN when defined.
module tb_shifter_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  ctrl0, ctrl1;
    logic        flag0, flag1;
    logic [31:0] opA0, opA1, opB0, opB1;
    logic        lock0, lock1;
    logic        ack0, ack1, done0, done1;
    logic [31:0] resultData;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clock = ~clock;

    shifter_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .ctrl0      (ctrl0),
        .ctrl1      (ctrl1),
        .flag0      (flag0),
        .flag1      (flag1),
        .opA0       (opA0),
        .opA1       (opA1),
        .opB0       (opB0),
        .opB1       (opB1),
        .lock0      (lock0),
        .lock1      (lock1),
        .ack0       (ack0),
        .ack1       (ack1),
        .done0      (done0),
        .done1      (done1),
        .resultData (resultData)
    );

    task automatic clearInputs();
        req0 = 0; req1 = 0; ctrl0 = 0; ctrl1 = 0; flag0 = 0; flag1 = 0;
        opA0 = 0; opA1 = 0; opB0 = 0; opB1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic quickReset();
        @(negedge clock); reset = 1; clearInputs();
        @(negedge clock); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; clearInputs(); req0 = 1; req1 = 1;
        repeat (2) @(negedge clock);
        #1;
        vecCount++;
        if ({ack0, ack1, done0, done1} !== 4'b0000) begin
            missCount++; $display("[TB] FAIL reset_flags got=%b exp=0000", {ack0, ack1, done0, done1});
        end
        vecCount++;
        if (resultData !== 32'h0) begin
            missCount++; $display("[TB] FAIL reset_result got=%h exp=00000000", resultData);
        end
        @(negedge clock); reset = 0; req0 = 0; req1 = 0; #1;
        vecCount++;
        if ({done0, done1} !== 2'b00 || resultData !== 32'h0) begin
            missCount++; $display("[TB] FAIL reset_release got=%b/%h exp=00/00000000", {done0, done1}, resultData);
        end
    endtask

    task automatic test_sll();
        @(negedge clock); req0 = 1; ctrl0 = 3'b100; opA0 = 32'h1; opB0 = 32'd4; #1;
        vecCount++;
        if ({ack0, ack1} !== 2'b10) begin
            missCount++; $display("[TB] FAIL sll_ack got=%b exp=10", {ack0, ack1});
        end
        @(negedge clock); req0 = 0; #1;
        vecCount++;
        if ({done0, done1} !== 2'b00) begin
            missCount++; $display("[TB] FAIL sll_early_done got=%b exp=00", {done0, done1});
        end
        @(negedge clock); #1;
        vecCount++;
        if ({done0, done1} !== 2'b10 || resultData !== 32'h10) begin
            missCount++; $display("[TB] FAIL sll_done got=%b/%h exp=10/00000010", {done0, done1}, resultData);
        end
        @(negedge clock); #1;
        vecCount++;
        if ({done0, done1} !== 2'b00 || resultData !== 32'h10) begin
            missCount++; $display("[TB] FAIL sll_hold got=%b/%h exp=00/00000010", {done0, done1}, resultData);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ctl [2];
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [31:0] exp [2];
        ctl = '{3'b110, 3'b111};
        a   = '{32'h80000000, 32'h00000001};
        b   = '{32'd4, 32'd1};
        exp = '{32'hF8000000, 32'h80000000};
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c < 2) begin
                req1 = 1; ctrl1 = ctl[c]; opA1 = a[c]; opB1 = b[c];
            end else begin
                req1 = 0;
            end
            #1;
            if (c < 2) begin
                vecCount++;
                if ({ack0, ack1} !== 2'b01) begin
                    missCount++; $display("[TB] FAIL b2b_ack[%0d] got=%b exp=01", c, {ack0, ack1});
                end
            end
            if (c >= 2 && c < 4) begin
                vecCount++;
                if ({done0, done1} !== 2'b01 || resultData !== exp[c-2]) begin
                    missCount++; $display("[TB] FAIL b2b_done[%0d] got=%b/%h exp=01/%h", c, {done0, done1}, resultData, exp[c-2]);
                end
            end
            if (c == 4) begin
                vecCount++;
                if ({done0, done1} !== 2'b00) begin
                    missCount++; $display("[TB] FAIL b2b_tail got=%b exp=00", {done0, done1});
                end
            end
        end
    endtask

    task automatic test_cmov();
        logic [2:0]  ctl [3];
        logic        flg [3];
        logic [31:0] exp [3];
        ctl = '{3'b011, 3'b011, 3'b000};
        flg = '{1'b1, 1'b0, 1'b1};
        exp = '{32'hAAAA5555, 32'h12345678, 32'h00000000};
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c < 3) begin
                req0 = 1; ctrl0 = ctl[c]; flag0 = flg[c]; opA0 = 32'hAAAA5555; opB0 = 32'h12345678;
            end else begin
                req0 = 0;
            end
            #1;
            if (c < 3) begin
                vecCount++;
                if ({ack0, ack1} !== 2'b10) begin
                    missCount++; $display("[TB] FAIL cmov_ack[%0d] got=%b exp=10", c, {ack0, ack1});
                end
            end
            if (c >= 2) begin
                vecCount++;
                if ({done0, done1} !== 2'b10 || resultData !== exp[c-2]) begin
                    missCount++; $display("[TB] FAIL cmov_done[%0d] got=%b/%h exp=10/%h", c, {done0, done1}, resultData, exp[c-2]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  expAck [4];
        logic [31:0] expRes [4];
`ifdef SHIFTER_ARBITER_RR_EN
        expAck = '{2'b10, 2'b01, 2'b10, 2'b01};
        expRes = '{32'h00000001, 32'h40000000, 32'h00000004, 32'h10000000};
`else
        expAck = '{2'b10, 2'b10, 2'b10, 2'b10};
        expRes = '{32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008};
`endif
        quickReset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clock);
            if (c < 4) begin
                req0 = 1; ctrl0 = 3'b100; opA0 = 32'h1;        opB0 = c;
                req1 = 1; ctrl1 = 3'b101; opA1 = 32'h80000000; opB1 = c;
            end else begin
                req0 = 0; req1 = 0;
            end
            #1;
            if (c < 4) begin
                vecCount++;
                if ({ack0, ack1} !== expAck[c]) begin
                    missCount++; $display("[TB] FAIL cont_ack[%0d] got=%b exp=%b", c, {ack0, ack1}, expAck[c]);
                end
            end
            if (c >= 2) begin
                vecCount++;
                if ({done0, done1} !== expAck[c-2] || resultData !== expRes[c-2]) begin
                    missCount++; $display("[TB] FAIL cont_done[%0d] got=%b/%h exp=%b/%h", c, {done0, done1}, resultData, expAck[c-2], expRes[c-2]);
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] expAck [5];
        expAck = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        quickReset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clock);
            req0 = (c >= 1 && c <= 4);
            req1 = (c <= 4);
            lock1 = (c <= 2);
            ctrl1 = 3'b100; opA1 = 32'h1; opB1 = c;
            ctrl0 = 3'b100; opA0 = 32'h3; opB0 = 32'h0;
            #1;
            if (c <= 4) begin
                vecCount++;
                if ({ack0, ack1} !== expAck[c]) begin
                    missCount++; $display("[TB] FAIL lock_ack[%0d] got=%b exp=%b", c, {ack0, ack1}, expAck[c]);
                end
            end
            if (c >= 2 && c <= 5) begin
                vecCount++;
                if ({done0, done1} !== 2'b01 || resultData !== (32'h1 << (c-2))) begin
                    missCount++; $display("[TB] FAIL lock_done1[%0d] got=%b/%h exp=01/%h", c, {done0, done1}, resultData, 32'h1 << (c-2));
                end
            end
            if (c == 6) begin
                vecCount++;
                if ({done0, done1} !== 2'b10 || resultData !== 32'h3) begin
                    missCount++; $display("[TB] FAIL lock_done0 got=%b/%h exp=10/00000003", {done0, done1}, resultData);
                end
            end
        end
        lock1 = 0;
    endtask

    task automatic test_reset_inflight();
        @(negedge clock); clearInputs(); req1 = 1; lock1 = 1; ctrl1 = 3'b100; opA1 = 32'h1; opB1 = 32'd8; #1;
        vecCount++;
        if ({ack0, ack1} !== 2'b01) begin
            missCount++; $display("[TB] FAIL rst_if_ack got=%b exp=01", {ack0, ack1});
        end
        @(negedge clock); reset = 1; req0 = 1; ctrl0 = 3'b110; opA0 = 32'h80000000; opB0 = 32'd31; #1;
        vecCount++;
        if ({ack0, ack1} !== 2'b00) begin
            missCount++; $display("[TB] FAIL rst_if_noack got=%b exp=00", {ack0, ack1});
        end
        @(negedge clock); reset = 0; #1;
        vecCount++;
        if ({done0, done1} !== 2'b00 || resultData !== 32'h0) begin
            missCount++; $display("[TB] FAIL rst_if_flush got=%b/%h exp=00/00000000", {done0, done1}, resultData);
        end
        vecCount++;
        if ({ack0, ack1} !== 2'b10) begin
            missCount++; $display("[TB] FAIL rst_if_regrant got=%b exp=10", {ack0, ack1});
        end
        @(negedge clock); req0 = 0; req1 = 0; lock1 = 0; #1;
        @(negedge clock); #1;
        vecCount++;
        if ({done0, done1} !== 2'b10 || resultData !== 32'hFFFFFFFF) begin
            missCount++; $display("[TB] FAIL rst_if_done got=%b/%h exp=10/ffffffff", {done0, done1}, resultData);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_back_to_back();
        test_cmov();
        test_contention();
        test_lock();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
